// File: rtl/lfsr_pkg.sv
// Shared LFSR tap table, XNOR feedback and checker state encodings.
// Reused by both the PRBS generator and the PRBS checker.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [63:0] bm(input int t);
        return (t > 0) ? (64'd1 << (t - 1)) : 64'd0;
    endfunction

    function automatic logic [63:0] taps4(input int a, input int b,
                                          input int c, input int d);
        return bm(a) | bm(b) | bm(c) | bm(d);
    endfunction

    // Tap positions are 1-based (tap 1 = LSB); unsupported widths give 0.
    function automatic logic [63:0] tap_mask(input int n);
        logic [63:0] m;
        case (n)
            3:       m = taps4(3, 2, 0, 0);
            4:       m = taps4(4, 3, 0, 0);
            5:       m = taps4(5, 3, 0, 0);
            6:       m = taps4(6, 5, 0, 0);
            7:       m = taps4(7, 6, 0, 0);
            8:       m = taps4(8, 6, 5, 4);
            9:       m = taps4(9, 5, 0, 0);
            10:      m = taps4(10, 7, 0, 0);
            11:      m = taps4(11, 9, 0, 0);
            12:      m = taps4(12, 6, 4, 1);
            13:      m = taps4(13, 4, 3, 1);
            14:      m = taps4(14, 5, 3, 1);
            15:      m = taps4(15, 14, 0, 0);
            16:      m = taps4(16, 15, 13, 4);
            17:      m = taps4(17, 14, 0, 0);
            18:      m = taps4(18, 11, 0, 0);
            19:      m = taps4(19, 6, 2, 1);
            20:      m = taps4(20, 17, 0, 0);
            21:      m = taps4(21, 19, 0, 0);
            22:      m = taps4(22, 21, 0, 0);
            23:      m = taps4(23, 18, 0, 0);
            24:      m = taps4(24, 23, 22, 17);
            25:      m = taps4(25, 22, 0, 0);
            26:      m = taps4(26, 6, 2, 1);
            27:      m = taps4(27, 5, 2, 1);
            28:      m = taps4(28, 25, 0, 0);
            29:      m = taps4(29, 27, 0, 0);
            30:      m = taps4(30, 6, 4, 1);
            31:      m = taps4(31, 28, 0, 0);
            32:      m = taps4(32, 22, 2, 1);
            64:      m = taps4(64, 63, 61, 60);
            default: m = 64'd0;
        endcase
        return m;
    endfunction

    // Every tap set has an even count, so the XNOR chain is inverted parity.
    function automatic logic lfsr_fb(input logic [63:0] v, input int n);
        return ~^(v & tap_mask(n));
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR step: previous word -> expected next word.
import lfsr_pkg::*;

module lfsr_next #(
    parameter int NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] prev,
    output logic [NUM_BITS-1:0] next
);

    assign next = {prev[NUM_BITS-2:0], lfsr_fb(64'(prev), NUM_BITS)};

endmodule

// File: rtl/prbs_check.sv
// PRBS checker: syncs to an XNOR LFSR stream, then flywheels and
// counts word errors, dropping lock after a run of mismatches.
import lfsr_pkg::*;

module prbs_check #(
    parameter int NUM_BITS = 32,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                E,
    input  logic [NUM_BITS-1:0] D,
    input  logic                CLR,
    output logic                LOCKED,
    output logic                ERR,
    output logic [CNT_W-1:0]    ERR_CNT,
    output logic                STUCK,
    output logic [1:0]          STATE
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(LOSS_CNT + 1);

    state_t              state, state_n;
    logic [NUM_BITS-1:0] prev, prev_n, expd;
    logic [MW-1:0]       match, match_n;
    logic [XW-1:0]       miss, miss_n;
    logic                locked_n, err_n, stuck_n;
    logic [CNT_W-1:0]    cnt_n;
    logic                ones, hit;

    lfsr_next #(.NUM_BITS(NUM_BITS)) u_next (
        .prev(prev),
        .next(expd)
    );

    assign ones = &D;
    assign hit  = (D == expd) && !ones;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            prev    <= '0;
            match   <= '0;
            miss    <= '0;
            LOCKED  <= 1'b0;
            ERR     <= 1'b0;
            STUCK   <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            state   <= state_n;
            prev    <= prev_n;
            match   <= match_n;
            miss    <= miss_n;
            LOCKED  <= locked_n;
            ERR     <= err_n;
            STUCK   <= stuck_n;
            ERR_CNT <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        prev_n   = prev;
        match_n  = match;
        miss_n   = miss;
        locked_n = LOCKED;
        err_n    = 1'b0;
        stuck_n  = E ? ones : STUCK;
        cnt_n    = CLR ? '0 : ERR_CNT;
        if (E) begin
            unique case (state)
                ST_IDLE: begin
                    prev_n  = D;
                    state_n = ST_SYNC;
                end
                ST_SYNC: begin
                    prev_n = D;
                    if (!hit) begin
                        match_n = '0;
                    end else if (match == MW'(LOCK_CNT - 1)) begin
                        match_n  = '0;
                        state_n  = ST_LOCKED;
                        locked_n = 1'b1;
                    end else begin
                        match_n = match + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    prev_n = expd;
                    if (hit) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        // A coincident clear keeps this error as the first count.
                        if (CLR)
                            cnt_n = CNT_W'(1);
                        else if (!(&ERR_CNT))
                            cnt_n = ERR_CNT + 1'b1;
                        if (miss == XW'(LOSS_CNT - 1)) begin
                            miss_n   = '0;
                            match_n  = '0;
                            prev_n   = D;
                            state_n  = ST_SYNC;
                            locked_n = 1'b0;
                        end else begin
                            miss_n = miss + 1'b1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_prbs_check.sv
// Randomized and directed bench for prbs_check (8-bit, 4-bit counter)
// against a sequence-level reference model.
module tb_prbs_check;

    localparam int NB = 8;
    localparam int LC = 4;
    localparam int LS = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, e, clr;
    logic [NB-1:0] d;
    logic          locked, err, stuck;
    logic [CW-1:0] err_cnt;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    int         m_state, m_match, m_miss, m_cnt;
    logic [7:0] m_prev;
    logic       m_err, m_stuck;

    always #5 clk = ~clk;

    prbs_check #(
        .NUM_BITS(NB),
        .LOCK_CNT(LC),
        .LOSS_CNT(LS),
        .CNT_W(CW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .E(e),
        .D(d),
        .CLR(clr),
        .LOCKED(locked),
        .ERR(err),
        .ERR_CNT(err_cnt),
        .STUCK(stuck),
        .STATE(state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Taps 8,6,5,4 -> mask B8; XNOR of four taps = 1 when tap parity is even.
    function automatic logic [7:0] nxt(input logic [7:0] w);
        logic b;
        b = ($countones(w & 8'hB8) % 2) == 0;
        return {w[6:0], b};
    endfunction

    task automatic model(input logic r, input logic en,
                         input logic [7:0] dv, input logic c);
        logic good;
        logic [7:0] ex;
        if (r) begin
            m_state = 0; m_prev = 0; m_match = 0; m_miss = 0;
            m_err = 0; m_stuck = 0; m_cnt = 0;
            return;
        end
        m_err = 0;
        if (en) begin
            ex      = nxt(m_prev);
            good    = (dv == ex) && (dv != 8'hFF);
            m_stuck = (dv == 8'hFF);
            if (m_state == 0) begin
                m_prev  = dv;
                m_state = 1;
            end else if (m_state == 1) begin
                m_prev = dv;
                if (good) m_match++;
                else m_match = 0;
                if (m_match == LC) begin
                    m_state = 2;
                    m_match = 0;
                end
            end else begin
                m_prev = ex;
                if (good) m_miss = 0;
                else begin
                    m_err = 1;
                    m_miss++;
                end
                if (m_miss == LS) begin
                    m_state = 1; m_match = 0; m_miss = 0; m_prev = dv;
                end
            end
        end
        if (c) m_cnt = m_err ? 1 : 0;
        else if (m_err && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic step(input logic r, input logic en,
                        input logic [7:0] dv, input logic c);
        rst = r; e = en; d = dv; clr = c;
        @(posedge clk);
        model(r, en, dv, c);
        #1;
        check("locked", int'(locked), m_state == 2 ? 1 : 0);
        check("state", int'(state), m_state);
        check("err", int'(err), int'(m_err));
        check("err_cnt", int'(err_cnt), m_cnt);
        check("stuck", int'(stuck), int'(m_stuck));
    endtask

    initial begin
        logic [7:0] w, dv;
        int bad_run;
        logic en, r, c;
        rst = 1; e = 0; d = 0; clr = 0;
        model(1'b1, 1'b0, 8'h00, 1'b0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check("rst_state", int'(state), 0);

        // Acquire lock on 00,01,03,07,0F
        w = 8'h00;
        step(0, 1, w, 0);
        for (int i = 0; i < 4; i++) begin
            w = nxt(w);
            step(0, 1, w, 0);
        end
        check("lock_word", int'(w), 8'h0F);
        check("lock_state", int'(state), 2);
        check("lock_cnt0", int'(err_cnt), 0);

        // Single corrupted word: 1F instead of 1E
        w = nxt(w);
        step(0, 1, 8'h1F, 0);
        check("single_err", int'(err), 1);
        check("single_cnt", int'(err_cnt), 1);
        w = nxt(w);
        step(0, 1, w, 0);
        check("after_3d_err", int'(err), 0);
        check("after_3d_lock", int'(locked), 1);

        // Idle cycle holds everything
        step(0, 0, 8'h55, 0);
        check("hold_state", int'(state), 2);
        for (int i = 0; i < 3; i++) begin
            w = nxt(w);
            step(0, 1, w, 0);
        end

        // Three bad words drop lock
        for (int i = 0; i < 3; i++) step(0, 1, 8'h55, 0);
        check("loss_cnt", int'(err_cnt), 4);
        check("loss_state", int'(state), 1);
        check("loss_locked", int'(locked), 0);

        // Relock on a valid sequence
        w = 8'h00;
        step(0, 1, w, 0);
        for (int i = 0; i < 4; i++) begin
            w = nxt(w);
            step(0, 1, w, 0);
        end
        check("relock", int'(locked), 1);

        // Alternate error/good to saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            w = nxt(w);
            step(0, 1, w ^ 8'h81, 0);
            w = nxt(w);
            step(0, 1, w, 0);
        end
        check("sat_cnt", int'(err_cnt), CMAX);
        w = nxt(w);
        step(0, 1, w ^ 8'h10, 1);
        check("clr_err_cnt", int'(err_cnt), 1);
        w = nxt(w);
        step(0, 1, w, 1);
        check("clr_cnt", int'(err_cnt), 0);

        // Reset mid-lock with E and CLR active
        check("pre_rst_lock", int'(locked), 1);
        step(1, 1, 8'hFF, 1);
        check("rst_lock_state", int'(state), 0);
        check("rst_lock_stuck", int'(stuck), 0);

        // Stuck all-ones stream never locks
        for (int i = 0; i < 8; i++) step(0, 1, 8'hFF, 0);
        check("stuck_flag", int'(stuck), 1);
        check("stuck_state", int'(state), 1);
        check("stuck_locked", int'(locked), 0);

        // Randomized stream with corruption, bursts, gaps, clears, resets
        w = 8'h00;
        bad_run = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 19) == 0);
            dv = 8'($urandom_range(0, 255));
            if (en) begin
                w  = nxt(w);
                dv = w;
                if (bad_run == 0 && $urandom_range(0, 49) == 0)
                    bad_run = $urandom_range(2, 4);
                if (bad_run > 0) begin
                    dv = dv ^ 8'($urandom_range(1, 255));
                    bad_run--;
                end else if ($urandom_range(0, 14) == 0) begin
                    dv = dv ^ 8'($urandom_range(1, 255));
                end else if ($urandom_range(0, 99) == 0) begin
                    dv = 8'hFF;
                end
            end
            step(r, en, dv, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
